// File: rtl/program_sequencer_pkg.sv
// Shared definitions for program_sequencer: state encoding and ROM word field positions.
package program_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    WAIT  = ST_WAIT,
    ISSUE = ST_ISSUE,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } state_t;

  // ROM word is {opcode, operand}; operand is twice the opcode width.
  function automatic int opc_msb(input int w); return 3*w - 1; endfunction
  function automatic int opc_lsb(input int w); return 2*w;     endfunction
  function automatic int opr_msb(input int w); return 2*w - 1; endfunction
  function automatic int opr_lsb(input int w); return 0 * w;   endfunction

  localparam int DEF_DATA_WIDTH = 4;
  localparam int OPC_MSB = opc_msb(DEF_DATA_WIDTH);
  localparam int OPC_LSB = opc_lsb(DEF_DATA_WIDTH);
  localparam int OPR_MSB = opr_msb(DEF_DATA_WIDTH);
  localparam int OPR_LSB = opr_lsb(DEF_DATA_WIDTH);

endpackage

// File: rtl/program_sequencer_seq_pc.sv
// Program counter for program_sequencer: clear, +1, +2, modulo 2^WIDTH.
module seq_pc #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc1,
  input  logic             inc2,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pc <= '0;
    else if (clr)  pc <= '0;
    else if (inc2) pc <= pc + WIDTH'(2);
    else if (inc1) pc <= pc + WIDTH'(1);
  end

endmodule

// File: rtl/program_sequencer.sv
// Instruction sequencer: fetches ROM words, issues them with a start strobe, handles skip/step/halt.
// Optional build macro SEQ_LOOP_EN: end-of-program wraps pc to 0 instead of finishing.
//
// state | meaning
// IDLE  | waiting for run after reset
// FETCH | ROM read issued at pc
// WAIT  | ROM data arrives, opcode/operand load
// ISSUE | start strobe, pc advance, end/halt decision
// PAUSE | single-step hold until step or halt_req
// DONE  | program finished, waiting for run
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ROM_ADDRESS_WIDTH = 5,
  parameter int INPUT_DATA_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          halt_req,
  input  logic                          step_en,
  input  logic                          step,
  input  logic [ROM_ADDRESS_WIDTH-1:0]  last_addr,
  output logic [ROM_ADDRESS_WIDTH-1:0]  rom_addr,
  output logic                          rom_en,
  input  logic [3*INPUT_DATA_WIDTH-1:0] rom_data,
  input  logic                          skip,
  output logic [INPUT_DATA_WIDTH-1:0]   opcode,
  output logic [2*INPUT_DATA_WIDTH-1:0] operand,
  output logic                          start,
  output logic                          busy,
  output logic                          done
);

  localparam int OPC_HI = opc_msb(INPUT_DATA_WIDTH);
  localparam int OPC_LO = opc_lsb(INPUT_DATA_WIDTH);
  localparam int OPR_HI = opr_msb(INPUT_DATA_WIDTH);
  localparam int OPR_LO = opr_lsb(INPUT_DATA_WIDTH);

  state_t                         state, next_state;
  logic                           halt_flag;
  logic                           halt_set;
  logic                           load_word;
  logic                           pc_clr, pc_inc1, pc_inc2;
  logic [ROM_ADDRESS_WIDTH-1:0]   pc;
  logic [ROM_ADDRESS_WIDTH-1:0]   pc_plus1;
  logic                           end_of_prog;
  logic                           halt_any;

  seq_pc #(.WIDTH(ROM_ADDRESS_WIDTH)) u_pc (
    .clk  (clk),
    .reset(reset),
    .clr  (pc_clr),
    .inc1 (pc_inc1),
    .inc2 (pc_inc2),
    .pc   (pc)
  );

  assign pc_plus1    = pc + ROM_ADDRESS_WIDTH'(1);
  // A skip landing past last_addr must also end the program.
  assign end_of_prog = (pc == last_addr) || (skip && (pc_plus1 == last_addr));
  assign halt_any    = halt_req || halt_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      halt_flag <= 1'b0;
      opcode    <= '0;
      operand   <= '0;
    end else begin
      state <= next_state;
      if (next_state == DONE) halt_flag <= 1'b0;
      else if (halt_set)      halt_flag <= 1'b1;
      if (load_word) begin
        opcode  <= rom_data[OPC_HI:OPC_LO];
        operand <= rom_data[OPR_HI:OPR_LO];
      end
    end
  end

  always_comb begin
    next_state = state;
    halt_set   = 1'b0;
    load_word  = 1'b0;
    pc_clr     = 1'b0;
    pc_inc1    = 1'b0;
    pc_inc2    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (run) begin
          next_state = FETCH;
          pc_clr     = 1'b1;
        end
      end
      FETCH: begin
        halt_set   = halt_req;
        next_state = WAIT;
      end
      WAIT: begin
        halt_set   = halt_req;
        load_word  = 1'b1;
        next_state = ISSUE;
      end
      ISSUE: begin
        pc_inc1 = !skip;
        pc_inc2 = skip;
`ifdef SEQ_LOOP_EN
        if (halt_any) begin
          next_state = DONE;
        end else begin
          pc_clr     = end_of_prog;
          next_state = step_en ? PAUSE : FETCH;
        end
`else
        if (end_of_prog || halt_any) next_state = DONE;
        else if (step_en)            next_state = PAUSE;
        else                         next_state = FETCH;
`endif
      end
      PAUSE: begin
        if (halt_req)  next_state = DONE;
        else if (step) next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  assign rom_addr = pc;
  assign rom_en   = (state == FETCH);
  assign start    = (state == ISSUE);
  assign busy     = (state == FETCH) || (state == WAIT) || (state == ISSUE) || (state == PAUSE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a registered ROM model and an issue log.
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_en = 1'b0;
  logic        step = 1'b0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  rom_addr;
  logic        rom_en;
  logic [11:0] rom_data = '0;
  logic        skip;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        start;
  logic        busy;
  logic        done;

  logic        skip_on = 1'b0;
  logic [7:0]  skip_opr = '0;
  logic [11:0] rom [32];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  q_opc [$];
  logic [7:0]  q_opr [$];
  int          q_cyc [$];

  program_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .halt_req (halt_req),
    .step_en  (step_en),
    .step     (step),
    .last_addr(last_addr),
    .rom_addr (rom_addr),
    .rom_en   (rom_en),
    .rom_data (rom_data),
    .skip     (skip),
    .opcode   (opcode),
    .operand  (operand),
    .start    (start),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // skip only matters in ISSUE, where operand identifies the instruction
  assign skip = skip_on && (operand == skip_opr);

  always @(negedge clk) begin
    if (start) begin
      q_opc.push_back(opcode);
      q_opr.push_back(operand);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 32; i++) rom[i] = {4'((i % 15) + 1), 8'(8'h40 + i)};
  endtask

  task automatic clear_log();
    q_opc.delete();
    q_opr.delete();
    q_cyc.delete();
  endtask

  task automatic run_pulse(output int rc);
    run = 1'b1;
    rc  = cyc;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk(tag, done, 1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n = 0;
    while (!start && n < budget) begin tick(); n++; end
    chk(tag, start, 1);
  endtask

  initial begin
    int rc, sc, n, dc;
    fill_rom();
    rom[0] = 12'h1A5;
    rom[1] = 12'h2B6;
    rom[2] = 12'h3C7;

    #12;
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_operand", operand, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    reset = 1'b1;
    tick();

`ifdef SEQ_LOOP_EN
    fill_rom();
    last_addr = 5'd1;
    clear_log();
    run_pulse(rc);
    n = 0;
    while (q_opr.size() < 5 && n < 60) begin tick(); n++; end
    halt_req = 1'b1;
    wait_done("loop_done", 20);
    halt_req = 1'b0;
    chk("loop_count", q_opr.size(), 6);
    for (int i = 0; i < 6 && i < q_opr.size(); i++)
      chk("loop_order", q_opr[i], 8'h40 + 8'(i % 2));

    last_addr = 5'd31;
    clear_log();
    run_pulse(rc);
    n = 0;
    while (q_opr.size() < 33 && n < 200) begin tick(); n++; end
    halt_req = 1'b1;
    wait_done("wrap_done", 20);
    halt_req = 1'b0;
    chk("wrap_count", q_opr.size(), 34);
    if (q_opr.size() >= 34) begin
      chk("wrap_at31", q_opr[31], 8'h5F);
      chk("wrap_to0", q_opr[32], 8'h40);
      chk("wrap_to1", q_opr[33], 8'h41);
    end
`else
    // basic run
    last_addr = 5'd2;
    clear_log();
    run_pulse(rc);
    chk("basic_fetch_en", rom_en, 1);
    chk("basic_fetch_addr", rom_addr, 0);
    chk("basic_busy", busy, 1);
    wait_done("basic_done", 30);
    dc = cyc;
    chk("basic_count", q_opr.size(), 3);
    if (q_opr.size() == 3) begin
      chk("basic_opc0", q_opc[0], 4'h1);
      chk("basic_opr0", q_opr[0], 8'hA5);
      chk("basic_opc1", q_opc[1], 4'h2);
      chk("basic_opr1", q_opr[1], 8'hB6);
      chk("basic_opc2", q_opc[2], 4'h3);
      chk("basic_opr2", q_opr[2], 8'hC7);
      chk("basic_first_lat", q_cyc[0] - rc, 3);
      chk("basic_gap01", q_cyc[1] - q_cyc[0], 3);
      chk("basic_gap12", q_cyc[2] - q_cyc[1], 3);
      chk("basic_done_lat", dc - q_cyc[2], 1);
    end
    chk("basic_hold_opc", opcode, 4'h3);
    chk("basic_busy_done", busy, 0);

    // skip at address 0, last_addr 3 -> 0, 2, 3
    fill_rom();
    last_addr = 5'd3;
    skip_on = 1'b1;
    skip_opr = 8'h40;
    clear_log();
    run_pulse(rc);
    wait_done("skip0_done", 40);
    chk("skip0_count", q_opr.size(), 3);
    if (q_opr.size() == 3) begin
      chk("skip0_a", q_opr[0], 8'h40);
      chk("skip0_b", q_opr[1], 8'h42);
      chk("skip0_c", q_opr[2], 8'h43);
    end

    // skip at address 2 with last_addr 3 -> ends without issuing 3
    skip_opr = 8'h42;
    clear_log();
    run_pulse(rc);
    wait_done("skip2_done", 40);
    skip_on = 1'b0;
    chk("skip2_count", q_opr.size(), 3);
    if (q_opr.size() == 3) chk("skip2_last", q_opr[2], 8'h42);

    // single step
    last_addr = 5'd2;
    step_en = 1'b1;
    clear_log();
    run_pulse(rc);
    wait_start("step_first", 10);
    tick();
    chk("step_pause_busy", busy, 1);
    chk("step_pause_start", start, 0);
    repeat (4) tick();
    chk("step_hold", q_opr.size(), 1);
    step = 1'b1;
    sc = cyc;
    tick();
    tick();
    step = 1'b0;
    wait_start("step_second", 10);
    tick();
    if (q_cyc.size() >= 2) chk("step_lat", q_cyc[1] - sc, 3);
    repeat (5) tick();
    chk("step_fetch_ignored", q_opr.size(), 2);
    chk("step_pause_busy2", busy, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_done("step_done", 20);
    chk("step_count", q_opr.size(), 3);
    step_en = 1'b0;

    // halt in WAIT, then restart
    last_addr = 5'd5;
    clear_log();
    run_pulse(rc);
    wait_start("halt_first", 10);
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_pending_start", start, 1);
    chk("halt_pending_opr", operand, 8'h41);
    tick();
    chk("halt_done", done, 1);
    chk("halt_count", q_opr.size(), 2);
    clear_log();
    run_pulse(rc);
    chk("restart_addr", rom_addr, 0);
    chk("restart_en", rom_en, 1);
    wait_done("restart_done", 40);
    chk("restart_count", q_opr.size(), 6);
    if (q_opr.size() == 6) begin
      chk("restart_first", q_opr[0], 8'h40);
      chk("restart_last", q_opr[5], 8'h45);
    end

    // reset in WAIT
    clear_log();
    run_pulse(rc);
    wait_start("rst_first", 10);
    tick();
    tick();
    chk("rst_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rom_en", rom_en, 0);
    chk("mid_rom_addr", rom_addr, 0);
    chk("mid_opcode", opcode, 0);
    chk("mid_operand", operand, 0);
    chk("mid_start", start, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    n = q_opr.size();
    tick();
    tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("mid_no_start", q_opr.size(), n);
    chk("mid_idle_busy", busy, 0);
    chk("mid_idle_done", done, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Sequences the execution unit from instruction ROM. It fetches 12-bit words (opcode + operand), presents them to the execution unit with a one-cycle `start` strobe, and advances the program counter, skipping one instruction when the datapath requests it. It supports run-to-end, single-step and halt, and sits between the instruction ROM and the execution unit in the CPU top level.

## Interface

Parameters:
- `ROM_ADDRESS_WIDTH`, default 5: program counter and ROM address width.
- `INPUT_DATA_WIDTH`, default 4: opcode width; the operand is 2× this width; the ROM word is 3× this width.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-low reset.
- `run`: input, 1 bit. Start pulse. Starts the program from address 0 when in IDLE or DONE.
- `halt_req`: input, 1 bit. Stop request, honoured at the next instruction boundary.
- `step_en`: input, 1 bit. Single-step mode enable.
- `step`: input, 1 bit. In PAUSE, releases the next instruction.
- `last_addr`: input, ROM_ADDRESS_WIDTH bits. Address of the final program instruction.
- `rom_addr`: output, ROM_ADDRESS_WIDTH bits. ROM read address.
- `rom_en`: output, 1 bit. ROM read enable. The ROM is registered: data is valid one cycle after `rom_en`.
- `rom_data`: input, 3×INPUT_DATA_WIDTH bits. Opcode is in `[11:8]`; operand is in `[7:0]`.
- `skip`: input, 1 bit. Skip-next request from the datapath, sampled in ISSUE.
- `opcode`: output, INPUT_DATA_WIDTH bits. Registered opcode to the execution unit.
- `operand`: output, 2×INPUT_DATA_WIDTH bits. Registered operand to the execution unit.
- `start`: output, 1 bit. One-cycle execute strobe.
- `busy`: output, 1 bit. High in FETCH, WAIT, ISSUE and PAUSE.
- `done`: output, 1 bit. High in DONE.

## Operation

States:
- IDLE → FETCH on `run`.
- FETCH drives `rom_en`=1 and `rom_addr`=pc → WAIT.
- WAIT: `opcode` and `operand` load from `rom_data` at the end of this cycle → ISSUE.
- ISSUE drives `start`=1 and samples `skip`. Next state:
  - DONE if end-of-program or `halt_req`;
  - else PAUSE if `step_en`;
  - else FETCH.
- PAUSE → FETCH on `step`; → DONE on `halt_req`. `halt_req` has priority if both are high.
- DONE → FETCH on `run`. pc is cleared to 0 on that transition.

PC update in ISSUE:
- pc ← pc+1, or pc+2 when `skip`=1.
- Arithmetic is modulo 2^ROM_ADDRESS_WIDTH.

End-of-program, evaluated in ISSUE on the old pc:
- pc == `last_addr`; or
- `skip`=1 and pc+1 == `last_addr`, so a skip never executes past the end.

Other rules:
- `run` outside IDLE and DONE is ignored.
- `step` outside PAUSE is ignored.
- `halt_req` in FETCH or WAIT is not lost. It is latched into a sticky flag, acted on in the following ISSUE, and cleared on entry to DONE.
- `opcode` and `operand` hold their last issued values outside WAIT; they are never cleared except by reset.
- `last_addr` is sampled every ISSUE. Software keeps it stable while `busy`.

## Timing

- Reset values (asynchronous, while `reset`=0): state=IDLE, pc=0, halt flag=0, `rom_en`=0, `rom_addr`=0, `opcode`=0, `operand`=0, `start`=0, `busy`=0, `done`=0.
- Instruction cadence is 3 cycles: FETCH, WAIT, ISSUE. Consecutive `start` pulses are 3 cycles apart.
- First `start` is 3 cycles after the `run` edge: run sampled at cycle 0; FETCH at 1, WAIT at 2, ISSUE at 3.
- `opcode` and `operand` are stable from the ISSUE cycle through the next WAIT.
- `done` rises the cycle after the final ISSUE.
- Reset asserted mid-program aborts immediately. No `start` is produced after reset asserts.
- `skip` and `halt_req` arriving in the same ISSUE cycle: the pc still updates by 2, then the block goes to DONE.

## Configuration

`SEQ_LOOP_EN`:
- Defined: end-of-program does not go to DONE. pc wraps to 0 and the block goes to FETCH (or to PAUSE if `step_en`). Only `halt_req` reaches DONE.
- Undefined: end-of-program goes to DONE as described above.

## Structure

- Shared package holds:
  - state encoding localparams (IDLE, FETCH, WAIT, ISSUE, PAUSE, DONE; 3-bit);
  - ROM word field positions (opcode MSB and LSB, operand MSB and LSB).
- One sub-module, `seq_pc`: the program counter register with load-zero, increment-by-1 and increment-by-2 controls and modulo wrap. The FSM lives in `program_sequencer`.

## Test plan

- Basic run: `last_addr`=2, ROM words 0x1A5, 0x2B6, 0x3C7, `run` pulse → three `start` pulses 3 cycles apart carrying opcodes 1, 2, 3 with operands A5, B6, C7; `done`=1 one cycle after the third pulse.
- Skip: `last_addr`=3, `skip`=1 on the instruction at address 0 → instructions at addresses 0, 2, 3 issue and address 1 never does. Skip at address 2 with `last_addr`=3 → DONE, and address 3 is not issued.
- Step mode: `step_en`=1 → after each `start` the block holds in PAUSE with `busy`=1. A `step` pulse gives the next `start` 3 cycles later. `step` in FETCH has no effect.
- Halt: `halt_req` pulsed in a WAIT cycle → the pending instruction still issues, then `done`=1. `run` → restarts from address 0.
- Reset mid-WAIT → all outputs 0 asynchronously, and no `start` follows.
- With `SEQ_LOOP_EN` defined, `last_addr`=1 → issue order is 0, 1, 0, 1, … until `halt_req`. With `last_addr`=31, the pc wraps from 31 to 0.
